// File: rtl/tcore_param.sv
// tcore_param: shared core width and divider FSM state encoding
package tcore_param;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_FIX, DIV_DONE} div_state_e;
endpackage

// File: rtl/seq_divider_rv.sv
// seq_divider_rv: multi-cycle RV32M restoring divider with RISC-V special cases and sign fix-up
module seq_divider_rv import tcore_param::*; #(
  parameter int WIDTH = XLEN
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             valid_o,
  output logic             dbz_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
  div_state_e state;
  logic [WIDTH-1:0] q, b, rem, q_nxt, rem_nxt, abs_a, abs_b;
  logic [WIDTH:0] t;
  logic [CW-1:0] cnt;
  logic neg_q, neg_r, sa, sb, is_dbz, is_ovf;
  always_comb begin
    t = {rem, q[WIDTH-1]} - {1'b0, b};
    q_nxt = {q[WIDTH-2:0], ~t[WIDTH]};
    rem_nxt = t[WIDTH] ? {rem[WIDTH-2:0], q[WIDTH-1]} : t[WIDTH-1:0];
    sa = signed_i & dividend_i[WIDTH-1];
    sb = signed_i & divisor_i[WIDTH-1];
    abs_a = sa ? -dividend_i : dividend_i;
    abs_b = sb ? -divisor_i : divisor_i;
    is_dbz = divisor_i == '0;
    is_ovf = signed_i && dividend_i == MIN_INT && divisor_i == '1;
  end
  assign busy_o = state == DIV_CALC || state == DIV_FIX;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= DIV_IDLE;
      done_o <= 1'b0;
      valid_o <= 1'b0;
      dbz_o <= 1'b0;
      quotient_o <= '0;
      remainder_o <= '0;
      q <= '0;
      b <= '0;
      rem <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        DIV_IDLE, DIV_DONE: begin
          state <= DIV_IDLE;
          if (start_i) begin
            valid_o <= 1'b0;
            dbz_o <= is_dbz;
            cnt <= '0;
            b <= abs_b;
            neg_q <= !is_dbz && !is_ovf && (sa ^ sb);
            neg_r <= !is_dbz && !is_ovf && sa;
            q <= is_dbz ? '1 : is_ovf ? MIN_INT : abs_a;
            rem <= is_dbz ? dividend_i : '0;
            state <= (is_dbz || is_ovf) ? DIV_FIX : DIV_CALC;
          end
        end
        DIV_CALC: begin
          q <= q_nxt;
          rem <= rem_nxt;
          cnt <= cnt + 1'b1;
          state <= cnt == CW'(WIDTH - 1) ? DIV_FIX : DIV_CALC;
        end
        DIV_FIX: begin
          quotient_o <= neg_q ? -q : q;
          remainder_o <= neg_r ? -rem : rem;
          done_o <= 1'b1;
          valid_o <= 1'b1;
          state <= DIV_DONE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end
endmodule
